alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
- Hardware control unit that drives the datapath control interface for register-register ALU instructions (add/sub/logic/shift, mul, div).
- Produces the per-step strobes (Rin/Rout one-hot, PCin/PCout, MARin, MDRin/MDRout, IRin, Yin, Z/HI/LO enables, Read, ALUop) that the datapath consumes.
- Runs fetch (T0-T2) and execute (T3-T6) from the IR fields, with a configurable memory wait.

Parameters:
- MEM_WAIT, 0: extra cycles T1 is held for memory read; legal range 0-15.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  asynchronous, active-high reset.
- run  in  1  level; while high, sequencer fetches/executes back-to-back instructions.
- ir  in  32  datapath IR output; opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- Rin  out  16  one-hot register write enable.
- Rout  out  16  one-hot register bus drive.
- PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, IncPC, Read  out  1 each  datapath strobes.
- Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin  out  1 each  Z/HI/LO strobes.
- ALUop  out  4  ALU operation select.
- busy  out  1  high in T0 through the final execute step.
- done  out  1  one-cycle pulse in the final execute step.
- illegal  out  1  high in ILLEGAL state.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, ILLEGAL.
- Moore outputs: decoded from state register plus the ir fields. Every strobe not listed for a state is 0.
- clear=1: state goes to IDLE immediately. All outputs 0 and wait counter 0 in the same delta, independent of clock.
- IDLE: all outputs 0. run=1 -> T0 next edge.
- T0: PCout, MARin, IncPC, Zlowin. -> T1.
- T1: Read and MDRin every cycle of the state; Zlowout and PCin on the first T1 cycle only.
  - 4-bit wait counter loads MEM_WAIT on entry and decrements each cycle.
  - Leave to T2 when counter=0, so T1 lasts MEM_WAIT+1 cycles.
- T2: MDRout, IRin. -> T3. IR is valid from T3 onward; decode uses ir only in T3-T6.
- Opcode classes:
  - 3-op: opcode 0x00-0x0A, ALUop=opcode[3:0].
  - mul: opcode 0x0B, ALUop=11.
  - div: opcode 0x0C, ALUop=12.
  - Any other opcode is illegal.
- T3: 3-op asserts Rout[Rb], Yin. mul/div asserts Rout[Ra], Yin. Illegal opcode: no strobes, -> ILLEGAL.
- T4: 3-op asserts Rout[Rc], ALUop, Zlowin. mul/div asserts Rout[Rb], ALUop, Zlowin, Zhighin. ALUop is 0 in every other state.
- T5: Zlowout. 3-op adds Rin[Ra] and done (final step). mul/div adds LOin.
- T6 (mul/div only): Zhighout, HIin, done.
- After the final step: run=1 -> T0 (no idle bubble); run=0 -> IDLE.
- run is sampled only in IDLE and at the final step. Dropping run mid-instruction does not abort it.
- ILLEGAL: illegal=1, busy=0, no strobes. Sticky until clear.
- Register indices decode as 4-bit to one-hot; index 0 is valid. Rin and Rout are never nonzero in the same cycle.

Test Plan:
- MEM_WAIT=0, clear pulse then run=1, ir=0x0291_0000 (add Ra=5, Rb=2, Rc=2) -> T0..T5 in 6 cycles. T3 Rout=0x0004; T4 Rout=0x0004, ALUop=0, Zlowin; T5 Rin=0x0020, done=1.
- div: ir opcode 0x0C, Ra=3, Rb=1 -> T3 Rout=0x0008, Yin; T4 Rout=0x0002, ALUop=12, Zlowin=Zhighin=1; T5 Zlowout, LOin; T6 Zhighout, HIin, done.
  - Same with a datapath model holding R3=0x54, R1=0x06 -> LO=0x0E, HI=0x00.
- MEM_WAIT=2, mul instruction -> T1 held 3 cycles with Read=MDRin=1 each cycle; PCin only in first; total 9 cycles T0-T6.
- ir opcode 0x1F -> ILLEGAL after T3 with no Rin/Yin. illegal stays 1 with run toggling; clear returns to IDLE with illegal=0.
- clear asserted between edges during T4 -> Zlowin and ALUop drop to 0 before the next edge; state IDLE; restart with run=1 begins at T0.
- run held high across two add instructions -> second T0 immediately follows first T5; run=0 at second T5 -> IDLE, busy=0.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// Hardwired control sequencer for register-register ALU instructions.
// Fetch runs T0-T2 (T1 stretched by MEM_WAIT); execute runs T3-T6 and decodes ir.
module alu_instr_sequencer #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] ir,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCin,
   output logic        PCout,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        IncPC,
   output logic        Read,
   output logic        Zlowin,
   output logic        Zhighin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic [3:0]  ALUop,
   output logic        busy,
   output logic        done,
   output logic        illegal
);

   localparam logic [3:0] StIdle    = 4'd0;
   localparam logic [3:0] StT0      = 4'd1;
   localparam logic [3:0] StT1      = 4'd2;
   localparam logic [3:0] StT2      = 4'd3;
   localparam logic [3:0] StT3      = 4'd4;
   localparam logic [3:0] StT4      = 4'd5;
   localparam logic [3:0] StT5      = 4'd6;
   localparam logic [3:0] StT6      = 4'd7;
   localparam logic [3:0] StIllegal = 4'd8;

   localparam logic [3:0] WaitInit = 4'(MEM_WAIT);

   logic [3:0] state_q, state_d;
   logic [3:0] wait_q, wait_d;

   logic [4:0]  opcode;
   logic [3:0]  ra, rb, rc;
   logic [15:0] ra_oh, rb_oh, rc_oh;
   logic        is_3op, is_mul, is_div, is_md, is_legal;
   logic        unused_ir;

   assign opcode    = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];

   assign ra_oh = 16'h0001 << ra;
   assign rb_oh = 16'h0001 << rb;
   assign rc_oh = 16'h0001 << rc;

   assign is_3op   = (opcode <= 5'd10);
   assign is_mul   = (opcode == 5'd11);
   assign is_div   = (opcode == 5'd12);
   assign is_md    = is_mul | is_div;
   assign is_legal = is_3op | is_md;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         StIdle: if (run) state_d = StT0;
         StT0: begin
            state_d = StT1;
            wait_d  = WaitInit;
         end
         StT1: begin
            if (wait_q == 4'd0) state_d = StT2;
            else                wait_d  = wait_q - 4'd1;
         end
         StT2: state_d = StT3;
         StT3: state_d = is_legal ? StT4 : StIllegal;
         StT4: state_d = StT5;
         StT5: begin
            if (is_md)    state_d = StT6;
            else if (run) state_d = StT0;
            else          state_d = StIdle;
         end
         StT6:      state_d = run ? StT0 : StIdle;
         StIllegal: state_d = StIllegal;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= StIdle;
         wait_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      Rin      = 16'h0000;
      Rout     = 16'h0000;
      PCin     = 1'b0;
      PCout    = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      Zlowin   = 1'b0;
      Zhighin  = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      ALUop    = 4'd0;
      busy     = 1'b0;
      done     = 1'b0;
      illegal  = 1'b0;
      case (state_q)
         StT0: begin
            busy   = 1'b1;
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
         end
         StT1: begin
            busy  = 1'b1;
            Read  = 1'b1;
            MDRin = 1'b1;
            // Counter still holds its load value only on the first T1 cycle.
            if (wait_q == WaitInit) begin
               PCin    = 1'b1;
               Zlowout = 1'b1;
            end
         end
         StT2: begin
            busy   = 1'b1;
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         StT3: begin
            busy = 1'b1;
            if (is_3op) begin
               Rout = rb_oh;
               Yin  = 1'b1;
            end else if (is_md) begin
               Rout = ra_oh;
               Yin  = 1'b1;
            end
         end
         StT4: begin
            busy = 1'b1;
            if (is_3op) begin
               Rout   = rc_oh;
               ALUop  = opcode[3:0];
               Zlowin = 1'b1;
            end else if (is_md) begin
               Rout    = rb_oh;
               ALUop   = is_mul ? 4'd11 : 4'd12;
               Zlowin  = 1'b1;
               Zhighin = 1'b1;
            end
         end
         StT5: begin
            busy    = 1'b1;
            Zlowout = 1'b1;
            if (is_md) begin
               LOin = 1'b1;
            end else begin
               Rin  = is_3op ? ra_oh : 16'h0000;
               done = 1'b1;
            end
         end
         StT6: begin
            busy     = 1'b1;
            Zhighout = 1'b1;
            HIin     = 1'b1;
            done     = 1'b1;
         end
         StIllegal: illegal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench: two sequencers (MEM_WAIT 0 and 2) checked each cycle against an
// instruction-level expected-step queue, plus literal checks and a small datapath model.
module tb_alu_instr_sequencer;

   localparam int unsigned MwA = 0;
   localparam int unsigned MwB = 2;

   localparam logic [31:0] IrAdd  = 32'h0291_0000; // add R5 = R2 + R2
   localparam logic [31:0] IrDiv  = 32'h6188_0000; // div R3 / R1
   localparam logic [31:0] IrMul  = 32'h5A30_0000; // mul R4 * R6
   localparam logic [31:0] IrOp10 = 32'h507C_0000; // opcode 0x0A, Ra=0 Rb=15 Rc=8
   localparam logic [31:0] IrBad  = 32'hF800_0000; // opcode 0x1F
   localparam logic [31:0] IrBadD = 32'h6800_0000; // opcode 0x0D

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic pcin, pcout, marin, mdrin, mdrout, irin, yin, incpc, read;
      logic zlowin, zhighin, zlowout, zhighout, hiin, loin;
      logic [3:0] aluop;
      logic busy, done, illegal;
   } out_t;

   logic        clock = 1'b0;
   logic        clear_a, clear_b, run;
   logic [31:0] ir;

   out_t act_a, act_b;
   logic [15:0] a_rin, a_rout, b_rin, b_rout;
   logic [3:0]  a_aluop, b_aluop;
   logic a_pcin, a_pcout, a_marin, a_mdrin, a_mdrout, a_irin, a_yin, a_incpc, a_read;
   logic a_zlowin, a_zhighin, a_zlowout, a_zhighout, a_hiin, a_loin, a_busy, a_done, a_ill;
   logic b_pcin, b_pcout, b_marin, b_mdrin, b_mdrout, b_irin, b_yin, b_incpc, b_read;
   logic b_zlowin, b_zhighin, b_zlowout, b_zhighout, b_hiin, b_loin, b_busy, b_done, b_ill;

   int   n_checks = 0;
   int   n_fail = 0;
   logic chk_en = 1'b0;
   out_t q_a[$];
   out_t q_b[$];
   logic ill_a = 1'b0;
   logic ill_b = 1'b0;

   always #5 clock = ~clock;

   alu_instr_sequencer #(.MEM_WAIT(MwA)) dut_a (
      .clock(clock), .clear(clear_a), .run(run), .ir(ir),
      .Rin(a_rin), .Rout(a_rout), .PCin(a_pcin), .PCout(a_pcout), .MARin(a_marin),
      .MDRin(a_mdrin), .MDRout(a_mdrout), .IRin(a_irin), .Yin(a_yin), .IncPC(a_incpc),
      .Read(a_read), .Zlowin(a_zlowin), .Zhighin(a_zhighin), .Zlowout(a_zlowout),
      .Zhighout(a_zhighout), .HIin(a_hiin), .LOin(a_loin), .ALUop(a_aluop),
      .busy(a_busy), .done(a_done), .illegal(a_ill)
   );

   alu_instr_sequencer #(.MEM_WAIT(MwB)) dut_b (
      .clock(clock), .clear(clear_b), .run(run), .ir(ir),
      .Rin(b_rin), .Rout(b_rout), .PCin(b_pcin), .PCout(b_pcout), .MARin(b_marin),
      .MDRin(b_mdrin), .MDRout(b_mdrout), .IRin(b_irin), .Yin(b_yin), .IncPC(b_incpc),
      .Read(b_read), .Zlowin(b_zlowin), .Zhighin(b_zhighin), .Zlowout(b_zlowout),
      .Zhighout(b_zhighout), .HIin(b_hiin), .LOin(b_loin), .ALUop(b_aluop),
      .busy(b_busy), .done(b_done), .illegal(b_ill)
   );

   assign act_a = {a_rin, a_rout, a_pcin, a_pcout, a_marin, a_mdrin, a_mdrout, a_irin, a_yin,
                   a_incpc, a_read, a_zlowin, a_zhighin, a_zlowout, a_zhighout, a_hiin, a_loin,
                   a_aluop, a_busy, a_done, a_ill};
   assign act_b = {b_rin, b_rout, b_pcin, b_pcout, b_marin, b_mdrin, b_mdrout, b_irin, b_yin,
                   b_incpc, b_read, b_zlowin, b_zhighin, b_zlowout, b_zhighout, b_hiin, b_loin,
                   b_aluop, b_busy, b_done, b_ill};

   // Register-transfer datapath driven by dut_a's strobes.
   logic [31:0] regs [16];
   logic [31:0] bus, y_r, zlo, zhi, lo, hi;
   logic        dp_init;

   always_comb begin
      bus = 32'h0;
      for (int i = 0; i < 16; i++) if (a_rout[i]) bus = regs[i];
      if (a_zlowout)  bus = zlo;
      if (a_zhighout) bus = zhi;
   end

   always @(posedge clock) begin
      if (dp_init) begin
         regs[1] <= 32'h06;
         regs[2] <= 32'h07;
         regs[3] <= 32'h54;
      end
      if (a_yin) y_r <= bus;
      if (a_zlowin) begin
         case (a_aluop)
            4'd0:  zlo <= y_r + bus;
            4'd1:  zlo <= y_r - bus;
            4'd11: {zhi, zlo} <= 64'(y_r) * 64'(bus);
            4'd12: begin
               zlo <= (bus != 0) ? y_r / bus : 32'h0;
               zhi <= (bus != 0) ? y_r % bus : 32'h0;
            end
            default: zlo <= 32'h0;
         endcase
      end
      if (a_loin) lo <= bus;
      if (a_hiin) hi <= bus;
      for (int i = 0; i < 16; i++) if (a_rin[i]) regs[i] <= bus;
   end

   // Appends the full expected step sequence of one instruction.
   task automatic push_instr(input int sel, input logic [31:0] irv);
      out_t        v;
      out_t        seq[$];
      logic [4:0]  opc;
      logic [15:0] ra1, rb1, rc1;
      int          mw, cls;
      opc = irv[31:27];
      ra1 = 16'h0001 << irv[26:23];
      rb1 = 16'h0001 << irv[22:19];
      rc1 = 16'h0001 << irv[18:15];
      mw  = (sel == 0) ? MwA : MwB;
      cls = (opc <= 5'd10) ? 0 : ((opc == 5'd11 || opc == 5'd12) ? 1 : 2);
      v = '0; v.busy = 1; v.pcout = 1; v.marin = 1; v.incpc = 1; v.zlowin = 1;
      seq.push_back(v);
      for (int i = 0; i <= mw; i++) begin
         v = '0; v.busy = 1; v.read = 1; v.mdrin = 1;
         if (i == 0) begin v.pcin = 1; v.zlowout = 1; end
         seq.push_back(v);
      end
      v = '0; v.busy = 1; v.mdrout = 1; v.irin = 1;
      seq.push_back(v);
      v = '0; v.busy = 1;
      if (cls == 0) begin v.rout = rb1; v.yin = 1; end
      if (cls == 1) begin v.rout = ra1; v.yin = 1; end
      seq.push_back(v);
      if (cls != 2) begin
         v = '0; v.busy = 1; v.zlowin = 1;
         if (cls == 0) begin v.rout = rc1; v.aluop = opc[3:0]; end
         else begin v.rout = rb1; v.aluop = (opc == 5'd11) ? 4'd11 : 4'd12; v.zhighin = 1; end
         seq.push_back(v);
         v = '0; v.busy = 1; v.zlowout = 1;
         if (cls == 0) begin v.rin = ra1; v.done = 1; end
         else v.loin = 1;
         seq.push_back(v);
         if (cls == 1) begin
            v = '0; v.busy = 1; v.zhighout = 1; v.hiin = 1; v.done = 1;
            seq.push_back(v);
         end
      end
      if (sel == 0) begin
         foreach (seq[i]) q_a.push_back(seq[i]);
         if (cls == 2) ill_a = 1'b1;
      end else begin
         foreach (seq[i]) q_b.push_back(seq[i]);
         if (cls == 2) ill_b = 1'b1;
      end
   endtask

   task automatic flush(input int sel);
      if (sel == 0) begin q_a.delete(); ill_a = 1'b0; end
      else begin q_b.delete(); ill_b = 1'b0; end
   endtask

   always @(negedge clock) begin
      out_t ea, eb;
      if (chk_en) begin
         if (q_a.size() > 0) ea = q_a.pop_front();
         else begin ea = '0; ea.illegal = ill_a; end
         if (q_b.size() > 0) eb = q_b.pop_front();
         else begin eb = '0; eb.illegal = ill_b; end
         n_checks++;
         if (act_a !== ea) begin
            n_fail++;
            $display("FAIL cycle_a @%0t: got %h expected %h", $time, act_a, ea);
         end
         n_checks++;
         if (act_b !== eb) begin
            n_fail++;
            $display("FAIL cycle_b @%0t: got %h expected %h", $time, act_b, eb);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clock);
      #1;
   endtask

   initial begin
      clear_a = 1; clear_b = 1; run = 0; ir = 32'h0; dp_init = 1;
      repeat (2) tick;
      dp_init = 0;
      chk("reset_a_outputs", 32'(act_a), 32'h0);
      chk("reset_b_outputs", 32'(act_b), 32'h0);
      chk_en = 1;
      clear_a = 0;
      tick;

      // add R5 = R2 + R2
      ir = IrAdd; run = 1; push_instr(0, IrAdd);
      tick; run = 0;
      repeat (3) tick;
      chk("add_t3_rout", 32'(a_rout), 32'h0004);
      chk("add_t3_yin", 32'(a_yin), 32'h1);
      tick;
      chk("add_t4_rout", 32'(a_rout), 32'h0004);
      chk("add_t4_zlowin", 32'(a_zlowin), 32'h1);
      tick;
      chk("add_t5_rin", 32'(a_rin), 32'h0020);
      chk("add_t5_done", 32'(a_done), 32'h1);
      tick;
      chk("add_idle_busy", 32'(a_busy), 32'h0);
      chk("add_r5", regs[5], 32'h0E);

      // div R3 / R1
      ir = IrDiv; run = 1; push_instr(0, IrDiv);
      tick; run = 0;
      repeat (3) tick;
      chk("div_t3_rout", 32'(a_rout), 32'h0008);
      tick;
      chk("div_t4_rout", 32'(a_rout), 32'h0002);
      chk("div_t4_aluop", 32'(a_aluop), 32'd12);
      chk("div_t4_zhighin", 32'(a_zhighin), 32'h1);
      tick;
      chk("div_t5_loin", 32'(a_loin), 32'h1);
      tick;
      chk("div_t6_done", 32'(a_done), 32'h1);
      tick;
      chk("div_lo", lo, 32'h0E);
      chk("div_hi", hi, 32'h00);

      // mul with MEM_WAIT=2
      clear_a = 1; flush(0); clear_b = 0;
      tick;
      ir = IrMul; run = 1; push_instr(1, IrMul);
      tick; run = 0;
      tick;
      chk("mul_t1a_pcin", 32'(b_pcin), 32'h1);
      chk("mul_t1a_read", 32'(b_read), 32'h1);
      tick;
      chk("mul_t1b_pcin", 32'(b_pcin), 32'h0);
      chk("mul_t1b_mdrin", 32'(b_mdrin), 32'h1);
      tick;
      chk("mul_t1c_read", 32'(b_read), 32'h1);
      repeat (5) tick;
      chk("mul_t6_done", 32'(b_done), 32'h1);
      tick;
      chk("mul_idle_busy", 32'(b_busy), 32'h0);

      // opcode 0x0D is just past div
      ir = IrBadD; run = 1; push_instr(1, IrBadD);
      tick; run = 0;
      repeat (7) tick;
      chk("op0d_illegal", 32'(b_ill), 32'h1);
      clear_b = 1; flush(1);
      tick;
      chk("op0d_cleared", 32'(b_ill), 32'h0);

      // opcode 0x1F: illegal, sticky across run toggles
      clear_a = 0;
      tick;
      ir = IrBad; run = 1; push_instr(0, IrBad);
      tick; run = 0;
      repeat (3) tick;
      chk("ill_t3_yin", 32'(a_yin), 32'h0);
      chk("ill_t3_rin", 32'(a_rin), 32'h0);
      tick;
      chk("ill_flag", 32'(a_ill), 32'h1);
      chk("ill_busy", 32'(a_busy), 32'h0);
      run = 1; tick; tick; run = 0; tick; run = 1; tick; run = 0;
      chk("ill_sticky", 32'(a_ill), 32'h1);
      clear_a = 1; flush(0);
      tick;
      chk("ill_cleared", 32'(a_ill), 32'h0);
      clear_a = 0;
      tick;

      // clear between edges in T4
      ir = IrDiv; run = 1; push_instr(0, IrDiv);
      tick; run = 0;
      repeat (4) tick;
      chk("clr_t4_aluop", 32'(a_aluop), 32'd12);
      #2 clear_a = 1; flush(0);
      #1;
      chk("clr_zlowin", 32'(a_zlowin), 32'h0);
      chk("clr_aluop", 32'(a_aluop), 32'h0);
      chk("clr_busy", 32'(a_busy), 32'h0);
      tick; clear_a = 0;
      tick;
      run = 1; push_instr(0, IrDiv);
      tick; run = 0;
      chk("clr_restart_pcout", 32'(a_pcout), 32'h1);
      repeat (7) tick;

      // back-to-back adds
      ir = IrAdd; run = 1; push_instr(0, IrAdd); push_instr(0, IrAdd);
      repeat (6) tick;
      chk("b2b_first_done", 32'(a_done), 32'h1);
      tick;
      chk("b2b_second_t0", 32'(a_pcout), 32'h1);
      repeat (5) tick;
      run = 0;
      chk("b2b_second_done", 32'(a_done), 32'h1);
      tick;
      chk("b2b_idle_busy", 32'(a_busy), 32'h0);

      // opcode 0x0A with register indices 0 and 15
      ir = IrOp10; run = 1; push_instr(0, IrOp10);
      tick; run = 0;
      repeat (3) tick;
      chk("op10_t3_rout", 32'(a_rout), 32'h8000);
      tick;
      chk("op10_t4_aluop", 32'(a_aluop), 32'd10);
      chk("op10_t4_rout", 32'(a_rout), 32'h0100);
      tick;
      chk("op10_t5_rin", 32'(a_rin), 32'h0001);
      repeat (2) tick;

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
